// File: rtl/gs_stream_pkg.sv
// Shared types and helpers for the GS raw-signal stream engine.
package gs_stream_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    CHECK,
    STREAM,
    FLUSH,
    DONE
  } gs_state_t;

  localparam int CMD_FIELD_W  = 8;
  localparam int CMD_CH_LSB   = 24;
  localparam int CMD_ADDR_LSB = 16;
  localparam int CMD_CNT_LSB  = 8;
  localparam int CMD_REP_LSB  = 0;

  // Port/counter width that never collapses to zero bits.
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/gs_sample_skid.sv
// Small circular FIFO that absorbs memory read returns while the packer
// is stalled; clr drops all contents in one cycle.
module gs_sample_skid
  import gs_stream_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int WIDTH = 16,
  parameter int OCC_W = clog2_min1(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [OCC_W-1:0] occupancy
);

  localparam int PTR_W = clog2_min1(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      if (push && !pop) occupancy <= occupancy + 1'b1;
      else if (!push && pop) occupancy <= occupancy - 1'b1;
    end
  end

endmodule

// File: rtl/gs_stream_engine.sv
// Command-driven sample streamer: reads a window of one sample memory,
// repeats it, packs samples into TX words and honours TX backpressure.
//
// state  | meaning
// IDLE   | waiting for a command in the RX FIFO
// LATCH  | RX FIFO data valid, capture command word
// CHECK  | validate channel, load address/count/repeat counters
// STREAM | issue reads, collect returns, pack and write words
// FLUSH  | write the padded partial word, if any
// DONE   | pulse oDone
module gs_stream_engine
  import gs_stream_pkg::*;
#(
  parameter int SAMPLE_W   = 16,
  parameter int PACK       = 2,
  parameter int ADDR_W     = 8,
  parameter int NUM_CH     = 4,
  parameter int MEM_LAT    = 1,
  parameter int SWAP_BYTES = 1
) (
  input  logic                          iClk,
  input  logic                          iReset,
  input  logic                          iCmdEmpty,
  output logic                          oCmdRdEn,
  input  logic [31:0]                   i32CmdData,
  output logic [clog2_min1(NUM_CH)-1:0] oMemChSel,
  output logic [ADDR_W-1:0]             oMemAddr,
  output logic                          oMemRdEn,
  input  logic [SAMPLE_W-1:0]           iMemData,
  output logic                          oTxWrEn,
  output logic [SAMPLE_W*PACK-1:0]      oTxData,
  input  logic                          iTxFull,
  input  logic                          iAbort,
  output logic                          oBusy,
  output logic                          oDone,
  output logic                          oError,
  output logic [15:0]                   o16WordCount
);

  localparam int CH_W       = clog2_min1(NUM_CH);
  localparam int SKID_DEPTH = MEM_LAT + 2;
  localparam int OCC_W      = clog2_min1(SKID_DEPTH + 1);
  localparam int LANE_W     = clog2_min1(PACK + 1);

  localparam logic [OCC_W:0]             FILL_MAX   = (OCC_W + 1)'(SKID_DEPTH);
  localparam logic [CMD_FIELD_W-1:0]     NUM_CH_B   = CMD_FIELD_W'(NUM_CH);
  localparam logic [LANE_W-1:0]          LANES_FULL = LANE_W'(PACK);

  gs_state_t                state;
  logic                     rst_done;
  logic [31:0]              cmd_q;
  logic [ADDR_W-1:0]        addr;
  logic [8:0]               remaining;
  logic [7:0]               reps;
  logic [MEM_LAT-1:0]       rd_pipe;
  logic [OCC_W-1:0]         pending;
  logic [LANE_W-1:0]        lane_idx;
  logic [SAMPLE_W*PACK-1:0] pack_data;

  logic [CMD_FIELD_W-1:0]   cmd_ch;
  logic [ADDR_W-1:0]        cmd_start;
  logic [CMD_FIELD_W-1:0]   cmd_cnt;
  logic [CMD_FIELD_W-1:0]   cmd_rep;
  logic [8:0]               count_full;
  logic [7:0]               reps_init;

  logic                     abort_now;
  logic                     skid_push;
  logic                     skid_pop;
  logic                     skid_clr;
  logic [SAMPLE_W-1:0]      sample_in;
  logic [SAMPLE_W-1:0]      skid_dout;
  logic [OCC_W-1:0]         skid_occ;
  logic [OCC_W:0]           fill_total;
  logic                     can_issue;
  logic                     stream_drained;
  logic                     tx_fire;

  assign cmd_ch     = cmd_q[CMD_CH_LSB +: CMD_FIELD_W];
  assign cmd_start  = cmd_q[CMD_ADDR_LSB +: ADDR_W];
  assign cmd_cnt    = cmd_q[CMD_CNT_LSB +: CMD_FIELD_W];
  assign cmd_rep    = cmd_q[CMD_REP_LSB +: CMD_FIELD_W];
  assign count_full = (cmd_cnt == '0) ? 9'd256 : {1'b0, cmd_cnt};
  assign reps_init  = (cmd_rep == '0) ? 8'd1 : cmd_rep;

  // RX FIFO delivers data the cycle after the strobe, i.e. during LATCH.
  assign oCmdRdEn  = rst_done && (state == IDLE) && !iCmdEmpty;
  assign abort_now = iAbort && (state != IDLE);

  if (SWAP_BYTES != 0) begin : g_swap
    assign sample_in = {iMemData[7:0], iMemData[SAMPLE_W-1:8]};
  end else begin : g_noswap
    assign sample_in = iMemData;
  end

  // Reads are only issued while the skid can hold every outstanding return.
  assign skid_push      = rd_pipe[MEM_LAT-1] && !abort_now;
  assign skid_clr       = abort_now;
  assign skid_pop       = (state == STREAM) && !iAbort && (lane_idx != LANES_FULL) && (skid_occ != '0);
  assign fill_total     = {1'b0, skid_occ} + {1'b0, pending};
  assign can_issue      = (state == STREAM) && (remaining != '0) && (fill_total < FILL_MAX);
  assign stream_drained = (remaining == '0) && (pending == '0) && (skid_occ == '0);
  assign tx_fire        = !iAbort && !iTxFull && (lane_idx != '0) &&
                          (((state == STREAM) && (lane_idx == LANES_FULL)) || (state == FLUSH));

  gs_sample_skid #(
    .DEPTH (SKID_DEPTH),
    .WIDTH (SAMPLE_W),
    .OCC_W (OCC_W)
  ) u_skid (
    .clk       (iClk),
    .rst       (iReset),
    .clr       (skid_clr),
    .push      (skid_push),
    .push_data (sample_in),
    .pop       (skid_pop),
    .pop_data  (skid_dout),
    .occupancy (skid_occ)
  );

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      state        <= IDLE;
      rst_done     <= 1'b0;
      cmd_q        <= '0;
      addr         <= '0;
      remaining    <= '0;
      reps         <= '0;
      rd_pipe      <= '0;
      pending      <= '0;
      lane_idx     <= '0;
      pack_data    <= '0;
      oMemChSel    <= '0;
      oMemAddr     <= '0;
      oMemRdEn     <= 1'b0;
      oTxWrEn      <= 1'b0;
      oTxData      <= '0;
      oBusy        <= 1'b0;
      oDone        <= 1'b0;
      oError       <= 1'b0;
      o16WordCount <= '0;
    end else begin
      rst_done <= 1'b1;
      oDone    <= 1'b0;
      oError   <= 1'b0;
      oTxWrEn  <= 1'b0;
      oMemRdEn <= 1'b0;
      rd_pipe  <= (rd_pipe << 1) | MEM_LAT'(oMemRdEn);

      if (abort_now) begin
        state     <= IDLE;
        oBusy     <= 1'b0;
        rd_pipe   <= '0;
        pending   <= '0;
        remaining <= '0;
        lane_idx  <= '0;
        pack_data <= '0;
      end else begin
        if (skid_pop) begin
          for (int k = 0; k < PACK; k++)
            if (lane_idx == LANE_W'(k)) pack_data[k*SAMPLE_W +: SAMPLE_W] <= skid_dout;
          lane_idx <= lane_idx + 1'b1;
        end else if (tx_fire) begin
          oTxWrEn   <= 1'b1;
          oTxData   <= pack_data;
          pack_data <= '0;
          lane_idx  <= '0;
          if (o16WordCount != 16'hFFFF) o16WordCount <= o16WordCount + 16'd1;
        end

        case (state)
          IDLE: begin
            if (oCmdRdEn) begin
              state <= LATCH;
              oBusy <= 1'b1;
            end
          end
          LATCH: begin
            cmd_q        <= i32CmdData;
            o16WordCount <= '0;
            state        <= CHECK;
          end
          CHECK: begin
            if (cmd_ch >= NUM_CH_B) begin
              oError <= 1'b1;
              oBusy  <= 1'b0;
              state  <= IDLE;
            end else begin
              oMemChSel <= cmd_ch[CH_W-1:0];
              addr      <= cmd_start;
              remaining <= count_full;
              reps      <= reps_init;
              state     <= STREAM;
            end
          end
          STREAM: begin
            if (can_issue) begin
              oMemRdEn <= 1'b1;
              oMemAddr <= addr;
              if ((remaining == 9'd1) && (reps > 8'd1)) begin
                addr      <= cmd_start;
                remaining <= count_full;
                reps      <= reps - 8'd1;
              end else begin
                addr      <= addr + 1'b1;
                remaining <= remaining - 9'd1;
              end
            end
            if (can_issue && !skid_push) pending <= pending + 1'b1;
            else if (!can_issue && skid_push) pending <= pending - 1'b1;
            if (stream_drained) state <= FLUSH;
          end
          FLUSH: begin
            if ((lane_idx == '0) || tx_fire) state <= DONE;
          end
          DONE: begin
            oDone <= 1'b1;
            oBusy <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gs_stream_engine.sv
// Directed bench for gs_stream_engine: command table plus backpressure
// and abort sequences, checked against a software packing model.
module tb_gs_stream_engine;

  localparam int MEM_LAT = 3;

  logic        clk = 1'b0;
  logic        iReset;
  logic        iCmdEmpty;
  logic        oCmdRdEn;
  logic [31:0] i32CmdData = '0;
  logic [1:0]  oMemChSel;
  logic [7:0]  oMemAddr;
  logic        oMemRdEn;
  logic [15:0] iMemData;
  logic        oTxWrEn;
  logic [31:0] oTxData;
  logic        iTxFull;
  logic        iAbort;
  logic        oBusy;
  logic        oDone;
  logic        oError;
  logic [15:0] o16WordCount;

  always #5 clk = ~clk;

  gs_stream_engine #(
    .SAMPLE_W   (16),
    .PACK       (2),
    .ADDR_W     (8),
    .NUM_CH     (4),
    .MEM_LAT    (MEM_LAT),
    .SWAP_BYTES (1)
  ) dut (
    .iClk         (clk),
    .iReset       (iReset),
    .iCmdEmpty    (iCmdEmpty),
    .oCmdRdEn     (oCmdRdEn),
    .i32CmdData   (i32CmdData),
    .oMemChSel    (oMemChSel),
    .oMemAddr     (oMemAddr),
    .oMemRdEn     (oMemRdEn),
    .iMemData     (iMemData),
    .oTxWrEn      (oTxWrEn),
    .oTxData      (oTxData),
    .iTxFull      (iTxFull),
    .iAbort       (iAbort),
    .oBusy        (oBusy),
    .oDone        (oDone),
    .oError       (oError),
    .o16WordCount (o16WordCount)
  );

  // Sample memory content: channel in the top nibble, 0x2 marker, address.
  function automatic logic [15:0] md(input logic [3:0] ch, input logic [7:0] a);
    return {ch, 4'h2, a};
  endfunction

  // RX command FIFO: data appears the cycle after the read strobe.
  logic [31:0] cmd_mem [16];
  int          cmd_wr = 0;
  int          cmd_rd = 0;
  assign iCmdEmpty = (cmd_rd == cmd_wr);
  always @(posedge clk) begin
    if (oCmdRdEn && (cmd_rd != cmd_wr)) begin
      i32CmdData <= cmd_mem[cmd_rd % 16];
      cmd_rd     <= cmd_rd + 1;
    end
  end

  // Sample memory with MEM_LAT = 3 cycle read pipeline.
  logic [15:0] mp0 = 16'hDEAD, mp1 = 16'hDEAD, mp2 = 16'hDEAD;
  always @(posedge clk) begin
    mp0 <= oMemRdEn ? md({2'b00, oMemChSel}, oMemAddr) : 16'hDEAD;
    mp1 <= mp0;
    mp2 <= mp1;
  end
  assign iMemData = mp2;

  // Output monitor, sampled on the falling edge.
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  int          done_cnt, err_cnt, rd_cnt, wr_while_full;
  logic        busy_at_err;
  logic        full_prev = 1'b0;
  always @(posedge clk) full_prev <= iTxFull;
  always @(negedge clk) begin
    if (oTxWrEn) got_q.push_back(oTxData);
    if (oTxWrEn && full_prev) wr_while_full++;
    if (oDone) done_cnt++;
    if (oError) begin
      err_cnt++;
      busy_at_err = oBusy;
    end
    if (oMemRdEn) rd_cnt++;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    got_q.delete();
    done_cnt      = 0;
    err_cnt       = 0;
    rd_cnt        = 0;
    wr_while_full = 0;
    busy_at_err   = 1'b1;
  endtask

  task automatic push_cmd(input logic [31:0] cmd);
    cmd_mem[cmd_wr % 16] = cmd;
    cmd_wr = cmd_wr + 1;
  endtask

  // Reference packing: byte-swapped samples, lane 0 low, last word zero-padded.
  task automatic build_model(input logic [31:0] cmd, output int n_reads);
    int          n, r, lane;
    logic [7:0]  a;
    logic [15:0] s;
    logic [31:0] w;
    exp_q.delete();
    n_reads = 0;
    if (cmd[31:24] >= 8'd4) return;
    n    = (cmd[15:8] == 8'd0) ? 256 : int'(cmd[15:8]);
    r    = (cmd[7:0] == 8'd0) ? 1 : int'(cmd[7:0]);
    lane = 0;
    w    = '0;
    for (int i = 0; i < n * r; i++) begin
      a = cmd[23:16] + 8'(i % n);
      s = md(cmd[27:24], a);
      if (lane == 0) w[15:0] = {s[7:0], s[15:8]};
      else           w[31:16] = {s[7:0], s[15:8]};
      lane++;
      if (lane == 2) begin
        exp_q.push_back(w);
        w    = '0;
        lane = 0;
      end
    end
    if (lane != 0) exp_q.push_back(w);
    n_reads = n * r;
  endtask

  task automatic wait_end(input string name);
    for (int c = 0; c < 5000 && (done_cnt + err_cnt) == 0; c++) begin
      @(posedge clk);
      #1;
    end
    check({name, "_end_seen"}, 64'(done_cnt + err_cnt), 64'd1);
  endtask

  task automatic check_seq(input string name, input int upto);
    int bad = 0;
    for (int i = 0; i < upto; i++)
      if (i >= got_q.size() || i >= exp_q.size() || got_q[i] !== exp_q[i]) bad++;
    check({name, "_word_mismatches"}, 64'(bad), 64'd0);
  endtask

  typedef struct {
    logic [31:0] cmd;
    bit          err;
    int          words;
    logic [31:0] first;
    logic [31:0] last;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int    n_reads;
    int    snap;
    string nm;

    vecs[0] = '{32'h01100401, 1'b0,   2, 32'h11121012, 32'h13121212};
    vecs[1] = '{32'h00FE0302, 1'b0,   3, 32'hFF02FE02, 32'h0002FF02};
    vecs[2] = '{32'h02200501, 1'b0,   3, 32'h21222022, 32'h00002422};
    vecs[3] = '{32'h07000401, 1'b1,   0, 32'h0,        32'h0       };
    vecs[4] = '{32'h03000001, 1'b0, 128, 32'h01320032, 32'hFF32FE32};
    vecs[5] = '{32'h00050100, 1'b0,   1, 32'h00000502, 32'h00000502};
    vecs[6] = '{32'h01400303, 1'b0,   5, 32'h41124012, 32'h00004212};

    iReset  = 1'b1;
    iTxFull = 1'b0;
    iAbort  = 1'b0;
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",    64'(oBusy),        64'd0);
    check("rst_txwr",    64'(oTxWrEn),      64'd0);
    check("rst_memrd",   64'(oMemRdEn),     64'd0);
    check("rst_cmdrd",   64'(oCmdRdEn),     64'd0);
    check("rst_wordcnt", 64'(o16WordCount), 64'd0);
    check("rst_txdata",  64'(oTxData),      64'd0);
    iReset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    for (int v = 0; v < 7; v++) begin
      nm = $sformatf("vec%0d", v);
      clear_mon();
      build_model(vecs[v].cmd, n_reads);
      push_cmd(vecs[v].cmd);
      wait_end(nm);
      repeat (3) @(posedge clk);
      #1;
      check({nm, "_error"},   64'(err_cnt),      64'(vecs[v].err));
      check({nm, "_done"},    64'(done_cnt),     64'(!vecs[v].err));
      check({nm, "_words"},   64'(got_q.size()), 64'(vecs[v].words));
      check({nm, "_wordcnt"}, 64'(o16WordCount), 64'(vecs[v].words));
      check({nm, "_reads"},   64'(rd_cnt),       64'(n_reads));
      check({nm, "_busy"},    64'(oBusy),        64'd0);
      if (vecs[v].err) begin
        check({nm, "_busy_at_err"}, 64'(busy_at_err), 64'd0);
      end else begin
        check({nm, "_first"}, 64'(got_q.size() > 0 ? got_q[0] : 32'hBAD0BAD0), 64'(vecs[v].first));
        check({nm, "_last"},  64'(got_q.size() > 0 ? got_q[got_q.size()-1] : 32'hBAD0BAD0), 64'(vecs[v].last));
        check_seq(nm, vecs[v].words);
      end
    end

    // Backpressure: TX full for 20 cycles in mid-stream.
    clear_mon();
    build_model(32'h01000A02, n_reads);
    push_cmd(32'h01000A02);
    for (int c = 0; c < 500 && got_q.size() < 2; c++) begin
      @(posedge clk);
      #1;
    end
    check("bp_started", 64'(got_q.size() >= 2), 64'd1);
    iTxFull = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("bp_stalled_busy", 64'(oBusy), 64'd1);
    iTxFull = 1'b0;
    wait_end("bp");
    repeat (3) @(posedge clk);
    #1;
    check("bp_words",      64'(got_q.size()),   64'd10);
    check("bp_wordcnt",    64'(o16WordCount),   64'd10);
    check("bp_wr_on_full", 64'(wr_while_full),  64'd0);
    check("bp_done",       64'(done_cnt),       64'd1);
    check_seq("bp", 10);

    // Abort a long command, then the queued one must stream normally.
    clear_mon();
    build_model(32'h02000001, n_reads);
    push_cmd(32'h02000001);
    push_cmd(32'h01100401);
    for (int c = 0; c < 500 && got_q.size() < 3; c++) begin
      @(posedge clk);
      #1;
    end
    check("ab_started", 64'(got_q.size() >= 3), 64'd1);
    iAbort = 1'b1;
    @(posedge clk);
    #1;
    iAbort = 1'b0;
    check("ab_busy_low", 64'(oBusy), 64'd0);
    snap = got_q.size();
    check_seq("ab_prefix", snap);
    @(posedge clk);
    #1;
    check("ab_no_partial", 64'(got_q.size()),  64'(snap));
    check("ab_cnt_hold",   64'(o16WordCount),  64'(snap));
    check("ab_no_done",    64'(done_cnt),      64'd0);
    check("ab_no_error",   64'(err_cnt),       64'd0);
    clear_mon();
    build_model(32'h01100401, n_reads);
    wait_end("ab_next");
    repeat (3) @(posedge clk);
    #1;
    check("ab_next_done",    64'(done_cnt),      64'd1);
    check("ab_next_words",   64'(got_q.size()),  64'd2);
    check("ab_next_wordcnt", 64'(o16WordCount),  64'd2);
    check("ab_next_first",   64'(got_q.size() > 0 ? got_q[0] : 32'hBAD0BAD0), 64'h11121012);
    check_seq("ab_next", 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
